// File: rtl/sonar_echo_buffer_mc.sv
// Multi-channel sonar echo store: NUM_CH ring buffers with addressed reads,
// per-channel clear/overflow, and a peak-hold/decay envelope feeding the DAC.

module sonar_echo_ch #(
  parameter int ADDR_W    = 7,
  parameter int DEPTH     = 128,
  parameter int OVERWRITE = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr,
  input  logic              i_clear,
  output logic [ADDR_W-1:0] o_wptr,
  output logic [ADDR_W:0]   o_count,
  output logic              o_ovf,
  output logic              o_accept
);
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W:0]   r_count;
  logic              r_ovf;
  logic              w_full;

  assign w_full   = (r_count == (ADDR_W+1)'(DEPTH));
  // A write that collides with a clear is discarded, including its RAM store.
  assign o_accept = i_wr && !i_clear && (!w_full || (OVERWRITE != 0));
  assign o_wptr   = r_wptr;
  assign o_count  = r_count;
  assign o_ovf    = r_ovf;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (i_clear) begin
      r_wptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (i_wr) begin
      if (!w_full) begin
        r_wptr  <= r_wptr + ADDR_W'(1);
        r_count <= r_count + (ADDR_W+1)'(1);
      end else begin
        r_ovf <= 1'b1;
        if (OVERWRITE != 0) r_wptr <= r_wptr + ADDR_W'(1);
      end
    end
  end
endmodule

module sonar_echo_buffer_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DATA  = 25,
  parameter int NUM_CH     = 4,
  parameter int CH_W       = $clog2(NUM_CH),
  parameter int DEPTH      = 128,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int DAC_WIDTH  = 12,
  parameter int OVERWRITE  = 1,
  parameter int DECAY_DIV  = 256
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_received_data,
  input  logic                  i_rd_en,
  input  logic [CH_W-1:0]       i_rd_ch,
  input  logic [ADDR_W-1:0]     i_read_add,
  input  logic [NUM_CH-1:0]     i_ch_clear,
  input  logic [CH_W-1:0]       i_dac_ch,
  output logic [FIFO_DATA-1:0]  o_read_data,
  output logic                  o_read_valid,
  output logic                  o_no_order,
  output logic [NUM_CH-1:0]     o_overflow,
  output logic [DAC_WIDTH-1:0]  o_outputDAC
);
  localparam int DW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [DW-1:0] DEC_LAST = DW'(DECAY_DIV - 1);

  logic [CH_W-1:0]                w_tag;
  logic [FIFO_DATA-1:0]           w_payload;
  logic [NUM_CH-1:0][ADDR_W-1:0]  w_wptr;
  logic [NUM_CH-1:0][ADDR_W:0]    w_count;
  logic [NUM_CH-1:0]              w_acc;

  assign w_tag     = i_received_data[FIFO_DATA +: CH_W];
  assign w_payload = i_received_data[FIFO_DATA-1:0];

  generate
    if (DATA_WIDTH > FIFO_DATA + CH_W) begin : g_spare
      logic w_unused_hi;
      assign w_unused_hi = ^i_received_data[DATA_WIDTH-1:FIFO_DATA+CH_W];
    end
  endgenerate

  genvar c;
  generate
    for (c = 0; c < NUM_CH; c++) begin : g_ch
      sonar_echo_ch #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .OVERWRITE(OVERWRITE)) u_ch (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_wr    (i_wr_en && (w_tag == CH_W'(c))),
        .i_clear (i_ch_clear[c]),
        .o_wptr  (w_wptr[c]),
        .o_count (w_count[c]),
        .o_ovf   (o_overflow[c]),
        .o_accept(w_acc[c])
      );
    end
  endgenerate

  // Channel-major RAM: index = {channel, slot}. Not reset.
  logic [FIFO_DATA-1:0] r_mem [NUM_CH*DEPTH];

  always_ff @(posedge i_clk) begin
    if (|w_acc) r_mem[{w_tag, w_wptr[w_tag]}] <= w_payload;
  end

  logic [ADDR_W:0]   w_rd_count;
  logic              w_rd_hit;
  logic [ADDR_W-1:0] w_rd_idx;

  assign w_rd_count = w_count[i_rd_ch];
  assign w_rd_hit   = ({1'b0, i_read_add} < w_rd_count);
  // Oldest = wptr - count; a full count of DEPTH truncates to 0, which is correct.
  assign w_rd_idx   = w_wptr[i_rd_ch] - w_rd_count[ADDR_W-1:0] + i_read_add;

  logic [FIFO_DATA-1:0] r_read_data;
  logic                 r_read_valid;
  logic                 r_no_order;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
      r_no_order   <= 1'b0;
    end else begin
      r_read_valid <= 1'b0;
      r_no_order   <= 1'b0;
      if (i_rd_en) begin
        if (w_rd_hit) begin
          r_read_valid <= 1'b1;
          r_read_data  <= r_mem[{i_rd_ch, w_rd_idx}];
        end else begin
          r_no_order  <= 1'b1;
          r_read_data <= '0;
        end
      end
    end
  end

  assign o_read_data  = r_read_data;
  assign o_read_valid = r_read_valid;
  assign o_no_order   = r_no_order;

  logic [DAC_WIDTH-1:0] w_top;
  logic                 w_env_wr;
  logic [DAC_WIDTH-1:0] r_peak;
  logic [DW-1:0]        r_decay;
  logic [CH_W-1:0]      r_dac_prev;

  assign w_top    = w_payload[FIFO_DATA-1 -: DAC_WIDTH];
  assign w_env_wr = w_acc[i_dac_ch];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_peak     <= '0;
      r_decay    <= '0;
      r_dac_prev <= '0;
    end else begin
      r_decay    <= (r_decay == DEC_LAST) ? '0 : r_decay + DW'(1);
      r_dac_prev <= i_dac_ch;
      if ((i_dac_ch != r_dac_prev) || i_ch_clear[i_dac_ch])
        r_peak <= '0;
      else if (w_env_wr && (w_top > r_peak))
        r_peak <= w_top;
      else if ((r_decay == DEC_LAST) && (r_peak != '0))
        r_peak <= r_peak - DAC_WIDTH'(1);
    end
  end

  assign o_outputDAC = r_peak;
endmodule

// File: tb/tb_sonar_echo_buffer_mc.sv
// Directed bench: two instances (overwrite / drop) share stimulus; read vectors
// are table-driven, multi-cycle corners are hand-written sequences.

module tb_sonar_echo_buffer_mc;
  logic        i_clk, i_rst_n, i_wr_en, i_rd_en;
  logic [31:0] i_received_data;
  logic [1:0]  i_rd_ch, i_dac_ch;
  logic [6:0]  i_read_add;
  logic [3:0]  i_ch_clear;

  logic [24:0] a_data, b_data;
  logic        a_vld, b_vld, a_nord, b_nord;
  logic [3:0]  a_ovf, b_ovf;
  logic [11:0] a_dac, b_dac;

  int n_chk = 0;
  int n_err = 0;

  sonar_echo_buffer_mc #(.OVERWRITE(1), .DECAY_DIV(4)) u_a (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr_en(i_wr_en), .i_received_data(i_received_data),
    .i_rd_en(i_rd_en), .i_rd_ch(i_rd_ch), .i_read_add(i_read_add), .i_ch_clear(i_ch_clear),
    .i_dac_ch(i_dac_ch), .o_read_data(a_data), .o_read_valid(a_vld), .o_no_order(a_nord),
    .o_overflow(a_ovf), .o_outputDAC(a_dac));

  sonar_echo_buffer_mc #(.OVERWRITE(0), .DECAY_DIV(4)) u_b (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr_en(i_wr_en), .i_received_data(i_received_data),
    .i_rd_en(i_rd_en), .i_rd_ch(i_rd_ch), .i_read_add(i_read_add), .i_ch_clear(i_ch_clear),
    .i_dac_ch(i_dac_ch), .o_read_data(b_data), .o_read_valid(b_vld), .o_no_order(b_nord),
    .o_overflow(b_ovf), .o_outputDAC(b_dac));

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [1:0]  ch;
    logic [6:0]  add;
    logic        nord;
    logic [24:0] exp_a;
    logic [24:0] exp_b;
  } rd_vec_t;

  rd_vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input int ch, input logic [24:0] p);
    i_wr_en = 1'b1;
    i_received_data = 32'(p) | (32'(ch) << 25);
    tick();
    i_wr_en = 1'b0;
  endtask

  task automatic rd(input rd_vec_t v);
    i_rd_en = 1'b1; i_rd_ch = v.ch; i_read_add = v.add;
    tick();
    i_rd_en = 1'b0;
    chk($sformatf("a_valid ch%0d+%0d", v.ch, v.add), 32'(a_vld), 32'(!v.nord));
    chk($sformatf("a_no_order ch%0d+%0d", v.ch, v.add), 32'(a_nord), 32'(v.nord));
    chk($sformatf("a_data ch%0d+%0d", v.ch, v.add), 32'(a_data), 32'(v.exp_a));
    chk($sformatf("b_no_order ch%0d+%0d", v.ch, v.add), 32'(b_nord), 32'(v.nord));
    chk($sformatf("b_data ch%0d+%0d", v.ch, v.add), 32'(b_data), 32'(v.exp_b));
  endtask

  initial begin
    vecs[0] = '{2'd2, 7'd0,   1'b0, 25'h10, 25'h10};
    vecs[1] = '{2'd2, 7'd4,   1'b0, 25'h14, 25'h14};
    vecs[2] = '{2'd2, 7'd5,   1'b1, 25'h0,  25'h0};
    vecs[3] = '{2'd2, 7'd2,   1'b0, 25'h12, 25'h12};
    vecs[4] = '{2'd0, 7'd0,   1'b1, 25'h0,  25'h0};
    vecs[5] = '{2'd2, 7'd127, 1'b1, 25'h0,  25'h0};
    vecs[6] = '{2'd0, 7'd0,   1'b0, 25'd2,   25'd0};
    vecs[7] = '{2'd0, 7'd127, 1'b0, 25'd129, 25'd127};
    vecs[8] = '{2'd0, 7'd64,  1'b0, 25'd66,  25'd64};
    vecs[9] = '{2'd1, 7'd0,   1'b1, 25'h0,   25'h0};

    i_rst_n = 1'b0; i_wr_en = 1'b0; i_rd_en = 1'b0; i_received_data = '0;
    i_rd_ch = '0; i_read_add = '0; i_ch_clear = '0; i_dac_ch = '0;
    #12;
    chk("reset read_data", 32'(a_data), 0);
    chk("reset read_valid", 32'(a_vld), 0);
    chk("reset no_order", 32'(a_nord), 0);
    chk("reset overflow", 32'(a_ovf), 0);
    chk("reset outputDAC", 32'(a_dac), 0);
    #5 i_rst_n = 1'b1;
    tick();

    // Basic fill and reads on channel 2.
    for (int i = 0; i < 5; i++) wr(2, 25'(16 + i));
    for (int v = 0; v < 6; v++) rd(vecs[v]);

    // Overfill channel 0: overwrite keeps newest 128, drop keeps first 128.
    for (int i = 0; i < 130; i++) wr(0, 25'(i));
    chk("a overflow[0]", 32'(a_ovf[0]), 1);
    chk("b overflow[0]", 32'(b_ovf[0]), 1);
    chk("a overflow[2]", 32'(a_ovf[2]), 0);
    for (int v = 6; v < 9; v++) rd(vecs[v]);
    tick();
    chk("hold read_valid", 32'(a_vld), 0);
    chk("hold read_data", 32'(a_data), 64 + 2);
    rd(vecs[9]);

    // Same-cycle write and read on channel 1 sees pre-write count.
    for (int i = 0; i < 3; i++) wr(1, 25'(256 + i));
    i_wr_en = 1'b1; i_received_data = 32'h103 | (32'd1 << 25);
    i_rd_en = 1'b1; i_rd_ch = 2'd1; i_read_add = 7'd3;
    tick();
    i_wr_en = 1'b0; i_rd_en = 1'b0;
    chk("same-cycle no_order", 32'(a_nord), 1);
    chk("same-cycle valid", 32'(a_vld), 0);
    rd('{2'd1, 7'd3, 1'b0, 25'h103, 25'h103});

    // Clear on channel 3 beats a same-cycle write; a same-cycle read still completes.
    for (int i = 0; i < 129; i++) wr(3, 25'(512 + i));
    chk("a overflow[3] set", 32'(a_ovf[3]), 1);
    chk("b overflow[3] set", 32'(b_ovf[3]), 1);
    i_ch_clear = 4'b1000;
    i_wr_en = 1'b1; i_received_data = 32'h3FF | (32'd3 << 25);
    i_rd_en = 1'b1; i_rd_ch = 2'd3; i_read_add = 7'd0;
    tick();
    i_ch_clear = '0; i_wr_en = 1'b0; i_rd_en = 1'b0;
    chk("clear-cycle read a", 32'(a_data), 513);
    chk("clear-cycle read b", 32'(b_data), 512);
    chk("clear-cycle valid", 32'(a_vld), 1);
    chk("a overflow after clear", 32'(a_ovf), 4'b0001);
    chk("b overflow after clear", 32'(b_ovf), 4'b0001);
    rd('{2'd3, 7'd0, 1'b1, 25'h0, 25'h0});

    // Envelope on channel 1.
    i_dac_ch = 2'd1;
    tick();
    wr(1, 25'h1000000);
    chk("env peak", 32'(a_dac), 12'h800);
    for (int i = 0; i < 8; i++) tick();
    chk("env decay 8cy", 32'(a_dac), 12'h7FE);
    wr(1, 25'h0FE0000);
    for (int i = 0; i < 3; i++) tick();
    chk("env smaller no lower", 32'(a_dac), 12'h7FD);
    chk("env b matches", 32'(b_dac), 12'h7FD);
    i_dac_ch = 2'd0;
    tick();
    chk("env switch zero", 32'(a_dac), 0);

    // Asynchronous reset in the middle of a burst.
    i_dac_ch = 2'd2;
    tick();
    wr(2, 25'h1FFFFFF);
    chk("env pre-reset", 32'(a_dac), 12'hFFF);
    rd('{2'd2, 7'd0, 1'b0, 25'h10, 25'h10});
    i_wr_en = 1'b1; i_received_data = 32'h1234 | (32'd2 << 25);
    #3 i_rst_n = 1'b0;
    #1;
    chk("async rst read_data", 32'(a_data), 0);
    chk("async rst outputDAC", 32'(a_dac), 0);
    chk("async rst overflow", 32'(a_ovf), 0);
    i_wr_en = 1'b0;
    #10 i_rst_n = 1'b1;
    tick();
    rd('{2'd0, 7'd0, 1'b1, 25'h0, 25'h0});
    rd('{2'd2, 7'd0, 1'b1, 25'h0, 25'h0});
    wr(0, 25'h55);
    rd('{2'd0, 7'd0, 1'b0, 25'h55, 25'h55});
    rd('{2'd0, 7'd1, 1'b1, 25'h0, 25'h0});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/sonar_echo_buffer_mc.md
Name: sonar_echo_buffer_mc

Overview:
- Multi-channel successor to the single-channel sonar echo store. Captures tagged echo samples from the receive front-end into NUM_CH independent ring buffers and serves addressed reads to the range-processing logic.
- Drives outputDAC with a peak-hold/decay envelope of one selectable channel for the analog display path.
- Adds per-channel clear, overflow reporting and selectable overwrite/drop-when-full mode.

Parameters:
DATA_WIDTH, 32, width of received_data word; must be >= FIFO_DATA+CH_W
FIFO_DATA, 25, stored sample payload width
NUM_CH, 4, number of echo channels (power of 2, >=2)
CH_W, $clog2(NUM_CH), channel select width
DEPTH, 128, entries per channel ring buffer (power of 2)
ADDR_W, $clog2(DEPTH), read offset width (7 at default)
DAC_WIDTH, 12, outputDAC width; must be <= FIFO_DATA
OVERWRITE, 1, 1 = overwrite oldest when full; 0 = drop new sample when full
DECAY_DIV, 256, envelope decay period in clk cycles

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  received_data valid this cycle
received_data  in  DATA_WIDTH  [FIFO_DATA-1:0] payload, [FIFO_DATA+CH_W-1:FIFO_DATA] channel tag, upper bits ignored
rd_en  in  1  read request
rd_ch  in  CH_W  channel to read
read_add  in  ADDR_W  offset from oldest stored entry of rd_ch
ch_clear  in  NUM_CH  per-channel clear pulse
dac_ch  in  CH_W  channel feeding the envelope DAC
read_data  out  FIFO_DATA  read result
read_valid  out  1  read_data valid (1-cycle pulse)
no_order  out  1  read rejected, offset not populated (1-cycle pulse)
overflow  out  NUM_CH  sticky per-channel overflow flags
outputDAC  out  DAC_WIDTH  envelope value

Behaviour:
- Reset (async on rst_n low): all pointers, counts, read_data, read_valid, no_order, overflow, outputDAC, decay counter = 0. Buffer RAM contents are not reset.
- Per channel c: wptr[c] (ADDR_W bits, wraps mod DEPTH) and count[c] (0..DEPTH). Oldest index = wptr - count mod DEPTH.
- Write, when wr_en and tag == c:
  - count < DEPTH: store at wptr, then wptr+1 and count+1.
  - count == DEPTH, OVERWRITE=1: store at wptr, wptr+1, count unchanged (oldest lost), overflow[c] set.
  - count == DEPTH, OVERWRITE=0: sample dropped, no state change, overflow[c] set.
- ch_clear[c]: wptr[c]=0, count[c]=0, overflow[c]=0 next cycle. Clear has priority over a same-cycle write to c (that write is discarded).
- Read:
  - Sampled on rd_en; result registered, latency 1 cycle.
  - If read_add < count[rd_ch]: read_data = entry (oldest + read_add) mod DEPTH, read_valid=1, no_order=0.
  - Otherwise: no_order=1, read_valid=0, read_data=0.
  - Without rd_en: read_valid = no_order = 0, read_data holds its value.
- Same-cycle read and write/clear on one channel: the read uses pre-update pointers/count and RAM contents (read-before-write). A clear in the same cycle does not cancel the read.
- Envelope:
  - sample_top = payload[FIFO_DATA-1 -: DAC_WIDTH], unsigned. Only accepted writes of channel dac_ch count (dropped samples do not).
  - Decay counter is free-running 0..DECAY_DIV-1 and wraps.
  - Priority each cycle:
    1. dac_ch differs from its registered previous value, or ch_clear[dac_ch]: peak=0.
    2. Qualifying write with sample_top > peak: peak=sample_top.
    3. Decay counter == DECAY_DIV-1 and peak > 0: peak-1.
    4. Otherwise hold.
  - outputDAC = peak register; no extra latency beyond that register.
- Several channels may be written only one per cycle (single tag). The tag must select a valid channel since NUM_CH is a power of 2.
- Reset asserted mid-operation clears all state immediately. The first write after deassertion lands at index 0.

Test Plan:
- Reset, write ch2 payloads 0x000010..0x000014 (5 writes), rd_en rd_ch=2 read_add=0 then 4 -> read_data 0x000010 / 0x000014 one cycle later, read_valid=1. Then read_add=5 -> no_order=1, read_data=0.
- OVERWRITE=1: 130 writes to ch0 with payload=i -> count 128, overflow[0]=1, read_add=0 returns 2, read_add=127 returns 129. OVERWRITE=0 build: read_add=0 returns 0, read_add=127 returns 127.
- Same cycle: write ch1 (count 3→4) with rd_en ch1 read_add=3 -> no_order=1. Next-cycle repeat -> read_valid=1 with new sample.
- ch_clear[3] with simultaneous ch3 write -> count[3]=0, overflow[3]=0, read_add=0 on ch3 gives no_order=1.
- dac_ch=1, DECAY_DIV=4, write ch1 sample_top 0x800 -> outputDAC=0x800, then decrements by 1 every 4 cycles. A sample_top 0x7F0 write does not lower it. Switching dac_ch to 0 -> outputDAC=0 next cycle.
- Assert rst_n low mid-burst -> all outputs 0 asynchronously; after release, read of any channel -> no_order=1.
